// File: rtl/count_chk_pkg.sv
// Shared types and default widths for the count-stream checker.
// The optional good-sample counter is enabled by defining CHK_GOOD_CNT_EN.
package count_chk_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_e;

    localparam int DATA_W = 8;
    localparam int ERR_W  = 8;
    localparam int GOOD_W = 16;

endpackage

// File: rtl/count_stream_checker_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear has priority over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Holds at all-ones instead of wrapping, so a long error burst stays visible.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/count_stream_checker.sv
// Locks onto an incrementing (mod 2^DATA_W) word stream and counts sequence errors.
// Defining CHK_GOOD_CNT_EN adds a good_count output counting matches while locked.
module count_stream_checker #(
    parameter int DATA_W   = count_chk_pkg::DATA_W,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = count_chk_pkg::ERR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              sample_en,
    input  logic              clear_err,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_count,
`ifdef CHK_GOOD_CNT_EN
    output logic [count_chk_pkg::GOOD_W-1:0] good_count,
`endif
    output logic [DATA_W-1:0] last_word
);

    import count_chk_pkg::*;

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(LOSS_CNT + 1);

    chk_state_e        state_q, state_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              have_prev_q, have_prev_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              err_pulse_q, err_pulse_d;
    logic              match;

    assign match = have_prev_q && (data_in == (prev_q + DATA_W'(1)));

    // Every accepted word re-anchors prev, so one corrupted word yields two mismatches.
    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        miss_d      = miss_q;
        have_prev_d = have_prev_q;
        prev_d      = prev_q;
        err_pulse_d = 1'b0;
        if (sample_en) begin
            prev_d      = data_in;
            have_prev_d = 1'b1;
            case (state_q)
                SEARCH: begin
                    if (!match) begin
                        run_d = '0;
                    end else if (run_q == RUN_W'(LOCK_CNT - 1)) begin
                        state_d = LOCKED;
                        run_d   = '0;
                        miss_d  = '0;
                    end else begin
                        run_d = run_q + RUN_W'(1);
                    end
                end
                LOCKED: begin
                    if (match) begin
                        miss_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (miss_q == MISS_W'(LOSS_CNT - 1)) begin
                            state_d = SEARCH;
                            run_d   = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + MISS_W'(1);
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SEARCH;
            run_q       <= '0;
            miss_q      <= '0;
            have_prev_q <= 1'b0;
            prev_q      <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            have_prev_q <= have_prev_d;
            prev_q      <= prev_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk_i   (clk),
        .reset_i (reset),
        .clr_i   (clear_err),
        .inc_i   (err_pulse_d),
        .count_o (err_count)
    );

`ifdef CHK_GOOD_CNT_EN
    logic good_inc;
    assign good_inc = sample_en && (state_q == LOCKED) && match;

    sat_counter #(.W(GOOD_W)) u_good_cnt (
        .clk_i   (clk),
        .reset_i (reset),
        .clr_i   (clear_err),
        .inc_i   (good_inc),
        .count_o (good_count)
    );
`endif

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign last_word = prev_q;

endmodule
